// File: rtl/mul_arb.sv
// mul_arb: round-robin sequencer sharing one start/done multiplier among NREQ requesters,
// with a watchdog that force-completes (err=1, q=0) a WAIT whose done never arrives.
module mul_arb #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 15
) (
    input  logic               c,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [32*NREQ-1:0] a,
    input  logic [32*NREQ-1:0] b,
    output logic [NREQ-1:0]    ack,
    output logic [31:0]        q,
    output logic               err,
    output logic               busy,
    output logic [31:0]        mul_a,
    output logic [31:0]        mul_b,
    output logic               mul_start,
    input  logic [31:0]        mul_q,
    input  logic               mul_done
);
    localparam int PW = $clog2(NREQ);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;
    state_t state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d, g_q, g_d, win;
    logic found;
    logic [7:0] cnt_q, cnt_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [31:0] q_q, q_d, mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic err_q, err_d, busy_q, busy_d, mul_start_q, mul_start_d;
    always_comb begin
        win = ptr_q;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[(int'(ptr_q) + i) % NREQ]) begin
                found = 1'b1;
                win = PW'((int'(ptr_q) + i) % NREQ);
            end
        end
    end
    always_comb begin
        state_d = state_q;
        ptr_d = ptr_q;
        g_d = g_q;
        cnt_d = cnt_q;
        ack_d = '0;
        q_d = q_q;
        err_d = err_q;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        mul_start_d = 1'b0;
        case (state_q)
            IDLE: if (found) begin
                g_d = win;
                mul_a_d = a[32*win +: 32];
                mul_b_d = b[32*win +: 32];
                mul_start_d = 1'b1;
                state_d = ISSUE;
            end
            ISSUE: begin
                cnt_d = '0;
                state_d = WAIT;
            end
            WAIT: if (mul_done) begin
                q_d = mul_q;
                err_d = 1'b0;
                ack_d[g_q] = 1'b1;
                state_d = ACK;
            end else if (cnt_q + 8'd1 == 8'(TIMEOUT)) begin
                q_d = '0;
                err_d = 1'b1;
                ack_d[g_q] = 1'b1;
                state_d = ACK;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
            ACK: begin
                ptr_d = (g_q == PW'(NREQ - 1)) ? '0 : g_q + 1'b1;
                state_d = IDLE;
            end
        endcase
        busy_d = state_d != IDLE;
    end
    always_ff @(posedge c) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q <= '0;
            g_q <= '0;
            cnt_q <= '0;
            ack_q <= '0;
            q_q <= '0;
            err_q <= 1'b0;
            busy_q <= 1'b0;
            mul_a_q <= '0;
            mul_b_q <= '0;
            mul_start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            g_q <= g_d;
            cnt_q <= cnt_d;
            ack_q <= ack_d;
            q_q <= q_d;
            err_q <= err_d;
            busy_q <= busy_d;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
            mul_start_q <= mul_start_d;
        end
    end
    assign ack = ack_q;
    assign q = q_q;
    assign err = err_q;
    assign busy = busy_q;
    assign mul_a = mul_a_q;
    assign mul_b = mul_b_q;
    assign mul_start = mul_start_q;
endmodule

// File: tb/tb_mul_arb.sv
// tb_mul_arb: requesters and a latency-programmable multiplier drive mul_arb; a transaction-level
// model (round-robin pick, product, timeout outcome, ack cycle) predicts every output cycle by cycle.
module tb_mul_arb;
    localparam int NREQ = 4;
    localparam int TIMEOUT = 15;
    logic c = 1'b0;
    logic rst = 1'b1;
    logic [NREQ-1:0] req = '0;
    logic [32*NREQ-1:0] a = '0;
    logic [32*NREQ-1:0] b = '0;
    logic [NREQ-1:0] ack;
    logic [31:0] q, mul_a, mul_b;
    logic err, busy, mul_start;
    logic [31:0] mul_q = '0;
    logic mul_done = 1'b0;
    int n_chk = 0;
    int n_err = 0;
    int mul_lat = 8;
    bit mul_never = 1'b0;
    bit stale_inj = 1'b0;
    int cyc = 0;
    int cd = -1;
    int ptr_m = 0;
    int req_cyc = 0;
    int due = 0;
    int w = 0;
    int last_lat = 0;
    bit pending = 1'b0;
    bit timed_out;
    logic [NREQ-1:0] req_prev = '0;
    logic [NREQ-1:0] exp_ack = '0;
    logic [NREQ-1:0] exp_now;
    logic [31:0] exp_q, exp_a, exp_b, last_q, prod;
    logic exp_err, last_err;
    int start_q[$];
    int ack_log[$];

    mul_arb #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .c(c), .rst(rst), .req(req), .a(a), .b(b), .ack(ack), .q(q), .err(err), .busy(busy),
        .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start), .mul_q(mul_q), .mul_done(mul_done)
    );

    always #5 c = ~c;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_chk++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++)
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    always @(negedge c) begin
        cyc++;
        exp_now = (pending && cyc == due) ? exp_ack : '0;
        chk("ack", 32'(ack), 32'(exp_now));
        if (exp_now != 0) begin
            chk("q", q, exp_q);
            chk("err", 32'(err), 32'(exp_err));
            ack_log.push_back(w);
            last_lat = cyc - req_cyc + 1;
            last_q = q;
            last_err = err;
            ptr_m = (w + 1) % NREQ;
            pending = 1'b0;
        end
        if (mul_start) begin
            chk("start_when_idle", 32'(pending), 32'(0));
            w = rr_pick(req_prev, ptr_m);
            if (w < 0) begin
                chk("start_without_req", 32'(0), 32'(1));
                w = 0;
            end
            exp_a = a[32*w +: 32];
            exp_b = b[32*w +: 32];
            chk("grant_a", mul_a, exp_a);
            chk("grant_b", mul_b, exp_b);
            exp_ack = NREQ'(1) << w;
            timed_out = mul_never || mul_lat > TIMEOUT;
            exp_err = timed_out;
            exp_q = timed_out ? 32'd0 : exp_a * exp_b;
            due = cyc + (timed_out ? TIMEOUT : mul_lat) + 1;
            pending = 1'b1;
            start_q.push_back(cyc);
        end
        chk("busy", 32'(busy), 32'(pending || exp_now != 0));
        if (pending) begin
            chk("hold_a", mul_a, exp_a);
            chk("hold_b", mul_b, exp_b);
        end
        if (req_prev == 0 && req != 0) req_cyc = cyc;
        req_prev = req;
        if (rst) begin
            pending = 1'b0;
            ptr_m = 0;
        end
        // Multiplier model: done L cycles after the start cycle; a new start supersedes an old one.
        mul_done = 1'b0;
        mul_q = $urandom;
        if (cd > 0) cd--;
        if (cd == 0) begin
            mul_done = 1'b1;
            mul_q = prod;
            cd = -1;
        end
        if (mul_start) begin
            prod = mul_a * mul_b;
            cd = mul_never ? -1 : mul_lat;
            if (stale_inj) begin
                mul_done = 1'b1;
                mul_q = ~prod;
            end
        end
    end

    task automatic rand_ops(input logic [NREQ-1:0] m);
        for (int i = 0; i < NREQ; i++)
            if (m[i]) begin
                a[32*i +: 32] = $urandom;
                b[32*i +: 32] = $urandom;
            end
    endtask

    task automatic run(input logic [NREQ-1:0] m, input int n, input bit hold);
        int got = 0;
        @(posedge c);
        #2 req = m;
        for (int k = 0; k < 500 && got < n; k++) begin
            @(posedge c);
            #2;
            if (ack != 0) begin
                got++;
                req = (got == n) ? '0 : (hold ? req : req & ~ack);
            end
        end
        req = '0;
        chk("ops_done", 32'(got), 32'(n));
        repeat (2) @(posedge c);
    endtask

    task automatic rst_pulse();
        @(posedge c);
        #2 rst = 1'b1;
        @(posedge c);
        #2 rst = 1'b0;
    endtask

    initial begin
        logic [NREQ-1:0] m;
        int n0;
        repeat (3) @(posedge c);
        #2 rst = 1'b0;
        @(negedge c);
        chk("rst_ack", 32'(ack), 32'(0));
        chk("rst_q", q, 32'(0));
        chk("rst_err", 32'(err), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_mul_a", mul_a, 32'(0));
        chk("rst_mul_b", mul_b, 32'(0));
        chk("rst_start", 32'(mul_start), 32'(0));
        a[31:0] = 32'd7;
        b[31:0] = 32'd6;
        start_q.delete();
        run(4'b0001, 1, 1'b0);
        chk("single_q", last_q, 32'd42);
        chk("single_err", 32'(last_err), 32'(0));
        chk("single_lat", 32'(last_lat), 32'd11);
        chk("single_start", 32'(start_q[0] - req_cyc), 32'd1);
        rst_pulse();
        for (int i = 0; i < NREQ; i++) begin
            a[32*i +: 32] = 32'(i + 2);
            b[32*i +: 32] = 32'd10;
        end
        ack_log.delete();
        start_q.delete();
        run(4'b1111, 8, 1'b1);
        for (int k = 0; k < 8; k++) chk("fair_order", 32'(ack_log[k]), 32'(k % 4));
        for (int k = 1; k < 8; k++) chk("fair_spacing", 32'(start_q[k] - start_q[k-1]), 32'd11);
        rst_pulse();
        rand_ops(4'b1111);
        run(4'b0100, 1, 1'b0);
        ack_log.delete();
        run(4'b0101, 2, 1'b0);
        chk("wrap_first", 32'(ack_log[0]), 32'd0);
        chk("wrap_second", 32'(ack_log[1]), 32'd2);
        run(4'b0001, 1, 1'b0);
        ack_log.delete();
        run(4'b1001, 2, 1'b0);
        chk("wrap_p1_first", 32'(ack_log[0]), 32'd3);
        chk("wrap_p1_second", 32'(ack_log[1]), 32'd0);
        mul_never = 1'b1;
        rand_ops(4'b0010);
        run(4'b0010, 1, 1'b0);
        mul_never = 1'b0;
        chk("timeout_err", 32'(last_err), 32'd1);
        chk("timeout_q", last_q, 32'd0);
        chk("timeout_lat", 32'(last_lat), 32'(TIMEOUT + 3));
        rand_ops(4'b0010);
        run(4'b0010, 1, 1'b0);
        chk("after_timeout_err", 32'(last_err), 32'd0);
        stale_inj = 1'b1;
        rand_ops(4'b1000);
        run(4'b1000, 1, 1'b0);
        stale_inj = 1'b0;
        chk("stale_lat", 32'(last_lat), 32'd11);
        mul_lat = TIMEOUT;
        rand_ops(4'b0100);
        run(4'b0100, 1, 1'b0);
        chk("collide_err", 32'(last_err), 32'd0);
        chk("collide_q", last_q, a[95:64] * b[95:64]);
        mul_lat = TIMEOUT + 1;
        run(4'b0100, 1, 1'b0);
        chk("late_err", 32'(last_err), 32'd1);
        mul_lat = 12;
        rand_ops(4'b0100);
        n0 = start_q.size();
        @(posedge c);
        #2 req = 4'b0100;
        for (int k = 0; k < 50 && start_q.size() == n0; k++) begin
            @(posedge c);
            #2;
        end
        chk("midrst_started", 32'(start_q.size() > n0), 32'd1);
        repeat (2) begin
            @(posedge c);
            #2;
        end
        rst = 1'b1;
        req = '0;
        @(posedge c);
        #2 rst = 1'b0;
        repeat (15) @(posedge c);
        @(negedge c);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_ack", 32'(ack), 32'd0);
        mul_lat = 8;
        rand_ops(4'b1000);
        run(4'b1000, 1, 1'b0);
        chk("midrst_next_err", 32'(last_err), 32'd0);
        chk("midrst_next_q", last_q, a[127:96] * b[127:96]);
        repeat (30) begin
            m = NREQ'($urandom_range(1, 15));
            mul_lat = $urandom_range(1, 18);
            mul_never = $urandom_range(0, 7) == 0;
            stale_inj = 1'($urandom_range(0, 1));
            rand_ops(m);
            run(m, $countones(m), 1'b0);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got no completion expected finish before 600000ns");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/mul_arb.md
Name: mul_arb

Overview:
- Round-robin arbiter/sequencer that shares one 32-bit pipelined multiplier (start/done interface) among NREQ requesters, e.g. the current loop, velocity estimator and feed-forward blocks of the motor controller.
- Runs one multiply at a time: latches the winner's operands, pulses start, waits for done, and returns the product with a one-cycle ack to that requester only.
- A watchdog ends any operation whose done never arrives.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 15, max cycles spent in WAIT before forced completion with error (1..255).

Ports:
- c  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- req  input  NREQ  per-requester request level; a[i], b[i] must be stable while req[i] is high.
- a  input  32*NREQ  operand A, requester i at bits [32*i+31:32*i].
- b  input  32*NREQ  operand B, same packing.
- ack  output  NREQ  one-cycle completion pulse, one-hot or zero.
- q  output  32  product, valid when any ack bit is high.
- err  output  1  high with ack when the operation timed out (q=0).
- busy  output  1  high in any state other than IDLE.
- mul_a  output  32  multiplier operand A.
- mul_b  output  32  multiplier operand B.
- mul_start  output  1  one-cycle multiplier start pulse.
- mul_q  input  32  multiplier result.
- mul_done  input  1  multiplier done indication.

Behaviour:
- All outputs are registered. After rst: state=IDLE, ack=0, q=0, err=0, busy=0, mul_a=0, mul_b=0, mul_start=0, rr pointer=0, timeout counter=0.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise grant the first set req bit at or after the pointer, searching upward with wrap NREQ-1 to 0.
  - Register mul_a/mul_b from the winner's operands and record its index g.
  - Go to ISSUE.
- ISSUE (1 cycle):
  - mul_start=1 this cycle only.
  - mul_a/mul_b hold from ISSUE through ACK.
  - mul_done seen in ISSUE is ignored as stale.
  - Go to WAIT; clear the timeout counter.
- WAIT:
  - On mul_done=1, capture mul_q into q, set err=0, go to ACK.
  - Otherwise increment the counter. If the counter reaches TIMEOUT with no done, set q=0 and err=1, go to ACK.
  - mul_done and timeout in the same cycle: done wins.
- ACK (1 cycle):
  - ack[g]=1; q and err are valid. Pointer becomes (g+1) mod NREQ. Go to IDLE.
  - Outside ACK, ack=0. q and err hold their last value.
- Requester contract:
  - The requester clears req[i] on the clock edge that ends its ack cycle.
  - IDLE samples req on the following cycle, so no duplicate issue occurs.
  - If req[i] stays high, a new operation is issued with the current operands, subject to round-robin order.
- Timing:
  - Request-to-ack latency = L+3 cycles, where L is the number of cycles from the mul_start cycle to the mul_done cycle. The 3 cycles are IDLE sample, ISSUE and ACK.
  - With the team multiplier (L=8), latency is 11 cycles. Throughput is one op per L+3 cycles.
- Dropped request: if req[g] drops mid-operation, the operation still completes and ack[g] still pulses. Requesters ignore an unexpected ack.
- Reset: rst mid-operation returns to IDLE next cycle with no ack. A subsequent late mul_done is ignored in IDLE.
- Arithmetic: q is the multiplier's 32-bit result unmodified; no truncation or sign handling in this block.

Test Plan:
- Single request: req=4'b0001, a0=7, b0=6, model mul with L=8 → mul_start 1 cycle after req; mul_a=7, mul_b=6 held; ack=4'b0001 with q=42, err=0, 11 cycles after req.
- Contention/fairness: req=4'b1111 held continuously, distinct operands (a_i=i+2, b_i=10) → ack order 0,1,2,3,0,… with q=20,30,40,50; each ack one-hot; starts spaced 11 cycles apart.
- Pointer wrap: pointer=3 (after servicing 2), req=4'b0101 → index 0 granted before 2. Next, with req=4'b1001 and pointer=1 → 3 granted, then 0.
- Timeout: mul model never asserts done, req=4'b0010 → ack=4'b0010, err=1, q=0 after TIMEOUT cycles in WAIT. busy stays high until ack, then drops. A following normal op gives err=0.
- Done/timeout collision and stale done: mul_done asserted in the ISSUE cycle is ignored. mul_done coinciding with the TIMEOUT cycle → err=0, q=mul_q.
- Reset mid-op: assert rst 3 cycles into WAIT, then a late mul_done → no ack, busy=0, pointer=0. Next req=4'b1000 completes normally with the correct product.
